// File: rtl/clk_div_pkg.sv
// Shared definitions for the odd-N clock divider: controller state encoding,
// default ratio limits and the ratio legality check.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } div_state_e;

    localparam int N_MIN_DEF = 3;
    localparam int N_MAX_DEF = 15;

    // A ratio is usable only if it is odd and inside the supported range.
    function automatic logic is_legal_odd(input int unsigned n,
                                          input int unsigned n_min = N_MIN_DEF,
                                          input int unsigned n_max = N_MAX_DEF);
        return n[0] && (n >= n_min) && (n <= n_max);
    endfunction

endpackage

// File: rtl/odd_div_phase_cnt.sv
// Divider phase counter: counts 0..div_n-1 and flags the last phase of each period.
// The clear input forces phase 0 so a new period starts cleanly after a reload.
module odd_div_phase_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] div_n,
    output logic [CNT_W-1:0] phase,
    output logic             wrap
);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;

    assign wrap  = (phase_q == (div_n - CNT_W'(1)));
    assign phase = phase_q;

    always_comb begin
        phase_d = phase_q + CNT_W'(1);
        if (clr || wrap) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/odd_div_ratio_ctrl.sv
// Run-time ratio controller for the odd-N divider: accepts ratio requests, switches
// the active ratio only at a period boundary and gates the divided clock around it.
module odd_div_ratio_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int N_MIN  = N_MIN_DEF,
    parameter int N_MAX  = N_MAX_DEF,
    parameter int N_RST  = 7,
    parameter int SETTLE = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_n,
    output logic             req_ready,
    output logic             req_err,
    output logic [CNT_W-1:0] div_n,
    output logic [CNT_W-1:0] phase,
    output logic             wrap,
    output logic             div_load,
    output logic             div_gate,
    output logic             busy
);

    localparam int SETTLE_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0]    N_RST_V     = CNT_W'(N_RST);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    div_n_q, div_n_d;
    logic [CNT_W-1:0]    pend_n_q, pend_n_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                div_gate_q, div_gate_d;
    logic                req_err_q, req_err_d;
    logic                transfer;

    odd_div_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (state_q == ST_LOAD),
        .div_n  (div_n_q),
        .phase  (phase),
        .wrap   (wrap)
    );

    assign req_ready = (state_q == ST_RUN);
    assign busy      = (state_q != ST_RUN);
    assign div_load  = (state_q == ST_LOAD);
    assign div_n     = div_n_q;
    assign div_gate  = div_gate_q;
    assign req_err   = req_err_q;
    assign transfer  = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        div_n_d      = div_n_q;
        pend_n_d     = pend_n_q;
        settle_cnt_d = settle_cnt_q;
        div_gate_d   = div_gate_q;
        req_err_d    = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (transfer) begin
                    if (!is_legal_odd(32'(req_n), N_MIN, N_MAX)) begin
                        req_err_d = 1'b1;
                    end else if (req_n != div_n_q) begin
                        pend_n_d = req_n;
                        state_d  = ST_ALIGN;
                    end
                end
            end
            // Gate drops on the last phase of the old period, so no partial pulse escapes.
            ST_ALIGN: begin
                if (wrap) begin
                    div_gate_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                div_n_d      = pend_n_q;
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if ((SETTLE == 0) || (wrap && (settle_cnt_q == SETTLE_LAST))) begin
                    div_gate_d = 1'b1;
                    state_d    = ST_RUN;
                end else if (wrap) begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_SETTLE;
            div_n_q      <= N_RST_V;
            pend_n_q     <= '0;
            settle_cnt_q <= '0;
            div_gate_q   <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_n_q      <= div_n_d;
            pend_n_q     <= pend_n_d;
            settle_cnt_q <= settle_cnt_d;
            div_gate_q   <= div_gate_d;
            req_err_q    <= req_err_d;
        end
    end

endmodule

// File: tb/tb_odd_div_ratio_ctrl.sv
// Self-checking bench for odd_div_ratio_ctrl: directed scenarios followed by random
// requests and resets, compared every cycle against a period-counting reference model.
module tb_odd_div_ratio_ctrl;

    localparam int CNT_W  = 4;
    localparam int N_RST  = 7;
    localparam int SETTLE = 2;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [CNT_W-1:0] req_n;
    logic             req_ready;
    logic             req_err;
    logic [CNT_W-1:0] div_n;
    logic [CNT_W-1:0] phase;
    logic             wrap;
    logic             div_load;
    logic             div_gate;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: ratio, phase and how many cycles remain in each switch stage.
    int m_n, m_phase, m_pend, m_align_left, m_settle_left;
    bit m_load, m_err;

    always #5 clk_in = ~clk_in;

    odd_div_ratio_ctrl #(
        .CNT_W  (CNT_W),
        .N_MIN  (3),
        .N_MAX  (15),
        .N_RST  (N_RST),
        .SETTLE (SETTLE)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .req_valid (req_valid),
        .req_n     (req_n),
        .req_ready (req_ready),
        .req_err   (req_err),
        .div_n     (div_n),
        .phase     (phase),
        .wrap      (wrap),
        .div_load  (div_load),
        .div_gate  (div_gate),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit mRun();
        return (m_align_left == 0) && !m_load && (m_settle_left == 0);
    endfunction

    function automatic int settleCycles(input int n);
        return (SETTLE == 0) ? 1 : SETTLE * n;
    endfunction

    task automatic modelReset();
        m_n           = N_RST;
        m_phase       = 0;
        m_pend        = 0;
        m_align_left  = 0;
        m_load        = 1'b0;
        m_settle_left = settleCycles(N_RST);
        m_err         = 1'b0;
    endtask

    task automatic modelStep(input bit r, input bit v, input int n);
        int  next_phase;
        bit  legal;
        if (r) begin
            modelReset();
            return;
        end
        next_phase = m_load ? 0 : ((m_phase == m_n - 1) ? 0 : m_phase + 1);
        legal      = (n % 2 == 1) && (n >= 3) && (n <= 15);
        m_err      = 1'b0;
        if (mRun()) begin
            if (v) begin
                if (!legal) begin
                    m_err = 1'b1;
                end else if (n != m_n) begin
                    m_pend       = n;
                    m_align_left = m_n - next_phase;
                end
            end
        end else if (m_align_left > 0) begin
            m_align_left--;
            if (m_align_left == 0) m_load = 1'b1;
        end else if (m_load) begin
            m_load        = 1'b0;
            m_n           = m_pend;
            m_settle_left = settleCycles(m_pend);
        end else begin
            m_settle_left--;
        end
        m_phase = next_phase;
    endtask

    task automatic checkAll();
        checkOutput("div_n", 32'(div_n), 32'(m_n));
        checkOutput("phase", 32'(phase), 32'(m_phase));
        checkOutput("wrap", 32'(wrap), 32'(m_phase == m_n - 1));
        checkOutput("div_gate", 32'(div_gate), 32'((m_settle_left == 0) && !m_load));
        checkOutput("req_ready", 32'(req_ready), 32'(mRun()));
        checkOutput("busy", 32'(busy), 32'(!mRun()));
        checkOutput("div_load", 32'(div_load), 32'(m_load));
        checkOutput("req_err", 32'(req_err), 32'(m_err));
    endtask

    // Checks the current cycle, then drives the inputs seen at the next rising edge.
    task automatic applyStimulus(input bit r, input bit v, input int n);
        @(negedge clk_in);
        checkAll();
        rst       = r;
        req_valid = v;
        req_n     = CNT_W'(n);
        modelStep(r, v, n);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 0);
    endtask

    initial begin
        int guard;
        bit cur_v;
        int cur_n;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_n     = '0;
        modelReset();
        @(posedge clk_in);
        applyStimulus(1'b1, 1'b0, 0);
        idle(20);

        applyStimulus(1'b0, 1'b1, 4);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1);
        idle(2);
        applyStimulus(1'b0, 1'b1, 7);
        idle(3);

        guard = 0;
        while (!(mRun() && m_phase == 2) && guard < 100) begin
            applyStimulus(1'b0, 1'b0, 0);
            guard++;
        end
        checkOutput("phase2_reached", 32'(guard < 100), 32'd1);
        applyStimulus(1'b0, 1'b1, 5);

        guard = 0;
        while (!mRun() && guard < 100) begin
            applyStimulus(1'b0, 1'b1, 9);
            guard++;
        end
        checkOutput("hold9_ready", 32'(guard < 100), 32'd1);
        applyStimulus(1'b0, 1'b1, 9);
        idle(30);

        applyStimulus(1'b0, 1'b1, 11);
        applyStimulus(1'b1, 1'b0, 0);
        idle(20);

        cur_v = 1'b0;
        cur_n = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(cur_v && !mRun())) begin
                cur_v = ($urandom_range(0, 2) == 0);
                cur_n = int'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 299) == 0) begin
                applyStimulus(1'b1, cur_v, cur_n);
            end else begin
                applyStimulus(1'b0, cur_v, cur_n);
            end
        end

        @(negedge clk_in);
        checkAll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
